// File: rtl/cpu_pipe_ctrl.sv
// cpu_pipe_ctrl: stall/flush resolution, redirect tracking and stall-cycle counting for the 5-stage pipeline
module cpu_pipe_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_req_if,
    input  logic        stall_req_id,
    input  logic        stall_req_ex,
    input  logic        stall_req_mem,
    input  logic        except_valid,
    input  logic [31:0] except_pc,
    input  logic        branch_valid,
    input  logic [31:0] branch_target,
    output logic [4:0]  stall,
    output logic [4:0]  flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic [31:0] stall_cycles
);
    localparam logic IDLE = 1'b0;
    localparam logic PEND = 1'b1;
    logic       state;
    logic       pend;
    logic       down_req;
    logic       branch_acc;
    logic [4:0] stall_base;
    logic [4:0] flush_base;
    always_comb begin
        pend       = state == PEND;
        down_req   = stall_req_id | stall_req_ex | stall_req_mem;
        branch_acc = branch_valid && !pend && !down_req;
        stall_base = {1'b0, stall_req_mem, stall_req_ex | stall_req_mem, down_req, down_req | stall_req_if};
        flush_base = {stall_req_mem, stall_req_ex & !stall_req_mem, stall_req_id & !(stall_req_ex | stall_req_mem),
                      stall_req_if & !down_req, 1'b0};
        redirect_valid = !rst && pend && !stall_req_if;
        stall = (rst || except_valid) ? 5'b00000 : stall_base;
        flush = rst ? 5'b11111 : except_valid ? 5'b11110 : flush_base | {3'b000, pend, 1'b0};
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            redirect_pc  <= 32'h0;
            stall_cycles <= 32'h0;
        end else begin
            if (except_valid) begin
                state       <= PEND;
                redirect_pc <= except_pc;
            end else if (branch_acc) begin
                state       <= PEND;
                redirect_pc <= branch_target;
            end else if (redirect_valid) begin
                state <= IDLE;
            end
            stall_cycles <= stall_cycles + {31'h0, stall[0]};
        end
    end
endmodule

// File: tb/tb_cpu_pipe_ctrl.sv
// tb_cpu_pipe_ctrl: directed scoreboard bench for cpu_pipe_ctrl
module tb_cpu_pipe_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        stall_req_if, stall_req_id, stall_req_ex, stall_req_mem;
    logic        except_valid, branch_valid;
    logic [31:0] except_pc, branch_target;
    logic [4:0]  stall, flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc, stall_cycles;
    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] exp_cnt = 32'h0;

    typedef struct {
        string       tag;
        logic [4:0]  st;
        logic [4:0]  fl;
        logic        rv;
        logic [31:0] pc;
        logic [31:0] cnt;
    } exp_t;
    exp_t sb[$];

    cpu_pipe_ctrl dut (
        .clk(clk), .rst(rst),
        .stall_req_if(stall_req_if), .stall_req_id(stall_req_id),
        .stall_req_ex(stall_req_ex), .stall_req_mem(stall_req_mem),
        .except_valid(except_valid), .except_pc(except_pc),
        .branch_valid(branch_valid), .branch_target(branch_target),
        .stall(stall), .flush(flush),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    // req = {mem, ex, id, if}
    task automatic step(input string tag, input logic r, input logic [3:0] req,
                        input logic ev, input logic [31:0] epc, input logic bv, input logic [31:0] bt,
                        input logic [4:0] st, input logic [4:0] fl, input logic rv, input logic [31:0] pc);
        exp_t e;
        rst = r;
        {stall_req_mem, stall_req_ex, stall_req_id, stall_req_if} = req;
        except_valid  = ev;
        except_pc     = epc;
        branch_valid  = bv;
        branch_target = bt;
        e.tag = tag; e.st = st; e.fl = fl; e.rv = rv; e.pc = pc; e.cnt = exp_cnt;
        sb.push_back(e);
        exp_cnt = r ? 32'h0 : exp_cnt + {31'h0, st[0]};
        @(negedge clk);
        e = sb.pop_front();
        vectors += 5;
        assert (stall === e.st) else begin
            miscompares++;
            $error("FAIL %s stall got %b exp %b", e.tag, stall, e.st);
        end
        assert (flush === e.fl) else begin
            miscompares++;
            $error("FAIL %s flush got %b exp %b", e.tag, flush, e.fl);
        end
        assert (redirect_valid === e.rv) else begin
            miscompares++;
            $error("FAIL %s redirect_valid got %b exp %b", e.tag, redirect_valid, e.rv);
        end
        assert (redirect_pc === e.pc) else begin
            miscompares++;
            $error("FAIL %s redirect_pc got %h exp %h", e.tag, redirect_pc, e.pc);
        end
        assert (stall_cycles === e.cnt) else begin
            miscompares++;
            $error("FAIL %s stall_cycles got %0d exp %0d", e.tag, stall_cycles, e.cnt);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        step("reset",      1, 4'b0000, 0, 0, 0, 0, 5'b00000, 5'b11111, 0, 32'h0);
        step("idle",       0, 4'b0000, 0, 0, 0, 0, 5'b00000, 5'b00000, 0, 32'h0);
        step("load_use",   0, 4'b0010, 0, 0, 0, 0, 5'b00011, 5'b00100, 0, 32'h0);
        step("idle_cnt",   0, 4'b0000, 0, 0, 0, 0, 5'b00000, 5'b00000, 0, 32'h0);
        step("nested",     0, 4'b0101, 0, 0, 0, 0, 5'b00111, 5'b01000, 0, 32'h0);
        step("mem_busy",   0, 4'b1000, 0, 0, 0, 0, 5'b01111, 5'b10000, 0, 32'h0);
        step("branch",     0, 4'b0000, 0, 0, 1, 32'hBFC00100, 5'b00000, 5'b00000, 0, 32'h0);
        step("br_redir",   0, 4'b0000, 0, 0, 0, 0, 5'b00000, 5'b00010, 1, 32'hBFC00100);
        step("br_idle",    0, 4'b0000, 0, 0, 0, 0, 5'b00000, 5'b00000, 0, 32'hBFC00100);
        step("br_id_stl",  0, 4'b0010, 0, 0, 1, 32'h00002000, 5'b00011, 5'b00100, 0, 32'hBFC00100);
        step("br_ignored", 0, 4'b0000, 0, 0, 0, 0, 5'b00000, 5'b00000, 0, 32'hBFC00100);
        step("exc_br_mem", 0, 4'b1000, 1, 32'h80000180, 1, 32'h00003000, 5'b00000, 5'b11110, 0, 32'hBFC00100);
        step("exc_wait1",  0, 4'b0001, 0, 0, 0, 0, 5'b00001, 5'b00010, 0, 32'h80000180);
        step("exc_wait2",  0, 4'b0001, 0, 0, 0, 0, 5'b00001, 5'b00010, 0, 32'h80000180);
        step("exc_wait3",  0, 4'b0001, 0, 0, 0, 0, 5'b00001, 5'b00010, 0, 32'h80000180);
        step("exc_redir",  0, 4'b0000, 0, 0, 0, 0, 5'b00000, 5'b00010, 1, 32'h80000180);
        step("exc_idle",   0, 4'b0000, 0, 0, 0, 0, 5'b00000, 5'b00000, 0, 32'h80000180);
        step("ovr_br",     0, 4'b0001, 0, 0, 1, 32'h00001000, 5'b00001, 5'b00010, 0, 32'h80000180);
        step("ovr_wait",   0, 4'b0001, 0, 0, 0, 0, 5'b00001, 5'b00010, 0, 32'h00001000);
        step("ovr_exc",    0, 4'b0001, 1, 32'h80000180, 0, 0, 5'b00000, 5'b11110, 0, 32'h00001000);
        step("ovr_redir",  0, 4'b0000, 0, 0, 0, 0, 5'b00000, 5'b00010, 1, 32'h80000180);
        step("ovr_idle",   0, 4'b0000, 0, 0, 0, 0, 5'b00000, 5'b00000, 0, 32'h80000180);
        step("same_br",    0, 4'b0000, 0, 0, 1, 32'h00004000, 5'b00000, 5'b00000, 0, 32'h80000180);
        step("same_exc",   0, 4'b0000, 1, 32'h00005000, 0, 0, 5'b00000, 5'b11110, 1, 32'h00004000);
        step("same_redir", 0, 4'b0000, 0, 0, 0, 0, 5'b00000, 5'b00010, 1, 32'h00005000);
        step("same_idle",  0, 4'b0000, 0, 0, 0, 0, 5'b00000, 5'b00000, 0, 32'h00005000);
        step("rp_br",      0, 4'b0001, 0, 0, 1, 32'h00006000, 5'b00001, 5'b00010, 0, 32'h00005000);
        step("rp_reset",   1, 4'b0001, 0, 0, 0, 0, 5'b00000, 5'b11111, 0, 32'h00006000);
        step("rp_after1",  0, 4'b0000, 0, 0, 0, 0, 5'b00000, 5'b00000, 0, 32'h0);
        step("rp_after2",  0, 4'b0000, 0, 0, 0, 0, 5'b00000, 5'b00000, 0, 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/cpu_pipe_ctrl.md
# cpu_pipe_ctrl

Pipeline control unit for the five-stage MIPS core (IF, ID, EX, MEM, WB). Collects stall requests from the stages, exception events from MEM and taken-branch/jump events from ID. Produces per-stage stall and flush vectors and a single PC redirect, so that no redirect is lost while instruction fetch is busy. Also keeps a free-running stall-cycle performance counter.

## Interface
- No parameters. Stage index for the vectors: 0=IF/PC, 1=ID, 2=EX, 3=MEM, 4=WB.
- Clocking: one clock; reset is synchronous and active-high.
- `clk`  in  1  core clock
- `rst`  in  1  synchronous active-high reset
- `stall_req_if`  in  1  instruction fetch busy; PC cannot accept a new address
- `stall_req_id`  in  1  load-use hazard from decode
- `stall_req_ex`  in  1  multi-cycle EX op (mul/div) busy
- `stall_req_mem`  in  1  data memory busy
- `except_valid`  in  1  exception or ERET committed in MEM this cycle
- `except_pc`  in  32  handler address or EPC for the exception
- `branch_valid`  in  1  taken branch/jump resolved in ID this cycle
- `branch_target`  in  32  branch/jump target
- `stall`  out  5  stall[i]=1: pipeline register feeding stage i holds its value
- `flush`  out  5  flush[i]=1: pipeline register feeding stage i loads a bubble
- `redirect_valid`  out  1  PC loads `redirect_pc` this cycle; overrides stall[0]
- `redirect_pc`  out  32  registered redirect target
- `stall_cycles`  out  32  count of cycles with stall[0]=1

## Operation
- Stall resolution is combinational. Let s = highest stage index with an active request (IF=0, ID=1, EX=2, MEM=3).
  - stall[j]=1 for all j≤s.
  - flush[s+1]=1 (bubble into the next stage).
  - Other bits are 0.
- State machine, two states:
  - IDLE: no redirect outstanding.
  - PEND: `redirect_pc` latched; redirect outstanding.
- Exception, `except_valid`=1, in any state:
  - flush[4:1]=4'b1111; stall=0 in that cycle (overrides all stall requests).
  - Latch `except_pc`; next state PEND.
- Branch, `branch_valid`=1, with no exception and none of `stall_req_id/ex/mem` active:
  - Latch `branch_target`; next state PEND.
  - No flush that cycle: the delay slot proceeds into ID.
  - A branch seen while ID is stalled is ignored; ID re-presents it.
  - A branch seen while in PEND is ignored.
- In PEND:
  - `redirect_valid` = !`stall_req_if`.
  - flush[1]=1 every PEND cycle, discarding wrong-path fetches.
  - stall[0]=1 in PEND cycles while `redirect_valid`=0.
  - Downstream stall requests still apply per the rule above.
  - Leave for IDLE on the cycle `redirect_valid`=1, unless `except_valid` is 1 in the same cycle: then relatch `except_pc` and stay in PEND.
- `stall_cycles` increments by 1 each non-reset cycle with stall[0]=1, including PEND wait cycles. It wraps from 0xFFFFFFFF to 0.

## Timing
- Reset values:
  - state IDLE, `redirect_pc`=0, `stall_cycles`=0, `redirect_valid`=0.
  - While `rst`=1: stall=5'b00000, flush=5'b11111.
- Reset mid-PEND drops the pending redirect; no `redirect_valid` follows.
- `stall` and `flush` depend combinationally on the current-cycle inputs and state. Same-cycle response, no register.
- Redirect latency: event in cycle N → earliest `redirect_valid` in N+1. Each cycle of `stall_req_if` adds one cycle.
- `redirect_valid` is exactly one cycle per accepted event. A superseding exception cancels the earlier target.
- Simultaneous exception and branch: the exception wins and the branch is dropped. Exception instructions are younger-flushed, so the branch never reissues.
- Simultaneous `stall_req_mem` and `except_valid`: the exception wins.

## Test plan
- Load-use: `stall_req_id`=1 for 1 cycle → stall=5'b00011, flush=5'b00100 that cycle; `stall_cycles` goes 0→1.
- Nested stalls: `stall_req_ex` and `stall_req_if` both 1 → stall=5'b00111, flush=5'b01000.
- Branch with no IF stall: `branch_valid`=1, `branch_target`=0xBFC00100 at N.
  - N: flush=0.
  - N+1: `redirect_valid`=1, `redirect_pc`=0xBFC00100, flush[1]=1.
  - N+2: state IDLE.
- Exception while fetch busy: `except_valid`=1, `except_pc`=0x80000180 at N, `stall_req_if`=1 for N+1..N+3.
  - N: flush=5'b11110.
  - N+1..N+3: flush[1]=1, stall[0]=1, `redirect_valid`=0.
  - N+4: `redirect_valid`=1 with 0x80000180.
- Override: branch pending to 0x1000 with IF busy; `except_valid`=1, `except_pc`=0x80000180 in PEND → the single subsequent redirect carries 0x80000180; 0x1000 never appears.
- Reset mid-PEND: `rst`=1 for one cycle → `redirect_valid` never asserts, `stall_cycles`=0, flush=5'b11111 during reset.
